// File: rtl/camara.sv
// camara: OV7670-class capture front-end; derives Xclk, drives sensor pins, and turns Vsyn/Href-framed
// byte pairs into RGB565 pixel writes, all in the clk domain.
module camara #(
  parameter int XCLK_DIV = 2,
  parameter int H_PIX    = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_div,
  input  logic              capture,
  input  logic              Vsyn,
  input  logic              Href,
  input  logic [7:0]        data,
  output logic              Xclk,
  output logic              Pclk,
  output logic              reset,
  output logic              PWDN,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_we,
  output logic              frame_done
);
  localparam int CW   = XCLK_DIV > 1 ? $clog2(XCLK_DIV) : 1;
  localparam int COLW = $clog2(H_PIX + 1);
  localparam int ROWW = $clog2(V_LINES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(XCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, WAIT_VS, SYNC, ACTIVE, DONE} state_t;

  state_t            r_state, w_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_xclk, r_rst_o, r_pwdn;
  logic              r_smp, r_vs, r_vs_p, r_hr, r_hr_p;
  logic [7:0]        r_d, r_hi;
  logic              r_ph, r_we, r_fd;
  logic [COLW-1:0]   r_col;
  logic [ROWW-1:0]   r_row;
  logic [ADDR_W-1:0] r_base, r_addr;
  logic [15:0]       r_data;
  logic              w_s_en, w_go, w_vs_rise, w_vs_fall, w_byte, w_hr_fall, w_act, w_row_ok, w_room;

  assign Xclk       = r_xclk;
  assign Pclk       = r_xclk;
  assign reset      = r_rst_o;
  assign PWDN       = r_pwdn;
  assign pix_data   = r_data;
  assign pix_addr   = r_addr;
  assign pix_we     = r_we;
  assign frame_done = r_fd;

  // s_en marks the clk edge on which Xclk rises; the sampled bytes are acted on one clk later (r_smp)
  assign w_s_en    = en_div & (r_cnt == C_MAX) & ~r_xclk;
  assign w_go      = capture & en_div;
  assign w_vs_rise = r_smp & r_vs & ~r_vs_p;
  assign w_vs_fall = r_smp & ~r_vs & r_vs_p;
  assign w_byte    = r_smp & r_hr & ~r_vs;
  assign w_hr_fall = r_smp & ~r_hr & r_hr_p & ~r_vs;
  assign w_act     = (r_state == ACTIVE) & w_go;
  assign w_row_ok  = r_row < ROWW'(V_LINES);
  assign w_room    = (r_col < COLW'(H_PIX)) & w_row_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_xclk  <= 1'b0;
      r_rst_o <= 1'b0;
      r_pwdn  <= 1'b1;
    end else begin
      r_rst_o <= 1'b1;
      r_pwdn  <= ~en_div;
      if (!en_div) begin
        r_cnt  <= '0;
        r_xclk <= 1'b0;
      end else if (r_cnt == C_MAX) begin
        r_cnt  <= '0;
        r_xclk <= ~r_xclk;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_smp  <= 1'b0;
      r_vs   <= 1'b0;
      r_vs_p <= 1'b0;
      r_hr   <= 1'b0;
      r_hr_p <= 1'b0;
      r_d    <= '0;
    end else begin
      r_smp <= w_s_en;
      if (w_s_en) begin
        r_vs   <= Vsyn;
        r_vs_p <= r_vs;
        r_hr   <= Href;
        r_hr_p <= r_hr;
        r_d    <= data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = w_go ? WAIT_VS : IDLE;
      WAIT_VS: w_nxt = w_vs_rise ? SYNC : WAIT_VS;
      SYNC:    w_nxt = w_vs_fall ? ACTIVE : SYNC;
      ACTIVE:  w_nxt = w_vs_rise ? DONE : ACTIVE;
      DONE:    w_nxt = SYNC;
      default: w_nxt = IDLE;
    endcase
    if (r_state != IDLE && !w_go) w_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we   <= 1'b0;
      r_fd   <= 1'b0;
      r_ph   <= 1'b0;
      r_hi   <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_base <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= 1'b0;
      r_fd <= (r_state == ACTIVE) & (w_nxt == DONE);
      if (r_state == SYNC && w_nxt == ACTIVE) begin
        r_col  <= '0;
        r_row  <= '0;
        r_ph   <= 1'b0;
        r_base <= '0;
        r_addr <= '0;
      end else if (w_act && w_byte) begin
        r_ph <= ~r_ph;
        if (!r_ph) begin
          r_hi <= r_d;
        end else if (w_room) begin
          r_we   <= 1'b1;
          r_data <= {r_hi, r_d};
          r_addr <= r_base + ADDR_W'(r_col);
          r_col  <= r_col + 1'b1;
        end
      end else if (w_act && w_hr_fall) begin
        r_col <= '0;
        r_ph  <= 1'b0;
        if (w_row_ok) begin
          r_row  <= r_row + 1'b1;
          r_base <= r_base + ADDR_W'(H_PIX);
        end
      end
    end
  end
endmodule

// File: tb/tb_camara.sv
// tb_camara: scoreboard bench for camara; camera bytes are held for one Xclk period (4 clk) each.
module tb_camara;
  localparam int H  = 8;
  localparam int V  = 3;
  localparam int AW = 5;

  logic          clk = 1'b0, rst = 1'b0, en_div = 1'b0, capture = 1'b0;
  logic          Vsyn = 1'b0, Href = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          Xclk, Pclk, reset, PWDN, pix_we, frame_done;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_addr;

  int total = 0, bad = 0, fd_cnt = 0;
  logic [AW+15:0] sb[$];
  logic [AW+15:0] e;

  camara #(.XCLK_DIV(2), .H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .en_div(en_div), .capture(capture), .Vsyn(Vsyn), .Href(Href),
    .data(data), .Xclk(Xclk), .Pclk(Pclk), .reset(reset), .PWDN(PWDN), .pix_data(pix_data),
    .pix_addr(pix_addr), .pix_we(pix_we), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_we) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pix_we_unexpected: got addr=%0d data=%h, required no write", pix_addr, pix_data);
      end else begin
        e = sb.pop_front();
        if ({pix_addr, pix_data} !== e) begin
          bad++;
          $display("FAIL pixel: got addr=%0d data=%h, required addr=%0d data=%h",
                   pix_addr, pix_data, e[AW+15:16], e[15:0]);
        end
      end
    end
    if (frame_done) begin
      fd_cnt++;
      total++;
      if (pix_we) begin
        bad++;
        $display("FAIL we_with_done: got pix_we=1 with frame_done=1, required pix_we=0");
      end
    end
  end

  function automatic logic [7:0] bv(input logic [7:0] b0, input logic [7:0] st, input int k);
    return b0 + 8'(k) * st;
  endfunction

  task automatic slot(input logic vs, input logic hr, input logic [7:0] d);
    Vsyn = vs;
    Href = hr;
    data = d;
    repeat (4) @(negedge clk);
  endtask

  task automatic vpulse();
    slot(1'b1, 1'b0, 8'h00);
    slot(1'b1, 1'b0, 8'h00);
    slot(1'b0, 1'b0, 8'h00);
    slot(1'b0, 1'b0, 8'h00);
  endtask

  task automatic line(input int n, input logic [7:0] b0, input logic [7:0] st, input int row);
    for (int p = 0; p < n / 2; p++)
      if (p < H && row < V) sb.push_back({AW'(row * H + p), bv(b0, st, 2 * p), bv(b0, st, 2 * p + 1)});
    for (int k = 0; k < n; k++) slot(1'b0, 1'b1, bv(b0, st, k));
    slot(1'b0, 1'b0, 8'h00);
    slot(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_done(input string nm, input int f0, input int want);
    total++;
    if (fd_cnt - f0 !== want) begin
      bad++;
      $display("FAIL %s_frame_done: got %0d pulses, required %0d", nm, fd_cnt - f0, want);
    end
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL %s_missing_writes: got %0d outstanding, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (10) @(negedge clk);
    total += 5;
    if (Xclk !== 1'b0) begin bad++; $display("FAIL rst_xclk: got %b required 0", Xclk); end
    if (PWDN !== 1'b1) begin bad++; $display("FAIL rst_pwdn: got %b required 1", PWDN); end
    if (reset !== 1'b0) begin bad++; $display("FAIL rst_reset: got %b required 0", reset); end
    if (pix_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b required 0", pix_we); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", frame_done); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (reset !== 1'b1) begin bad++; $display("FAIL rst_release: got reset=%b required 1", reset); end
    @(negedge clk);
  endtask

  task automatic test_divider();
    logic hi = 1'b0, prev;
    int t1 = -1, t2 = -1;
    en_div = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (Xclk) hi = 1'b1;
    end
    total += 2;
    if (hi !== 1'b0) begin bad++; $display("FAIL div_off_xclk: got high, required constant 0"); end
    if (PWDN !== 1'b1) begin bad++; $display("FAIL div_off_pwdn: got %b required 1", PWDN); end
    en_div = 1'b1;
    @(negedge clk);
    total++;
    if (PWDN !== 1'b0) begin bad++; $display("FAIL div_on_pwdn: got %b required 0", PWDN); end
    prev = Xclk;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      @(negedge clk);
      if (Xclk && !prev) begin
        if (t1 < 0) t1 = i;
        else t2 = i;
      end
      prev = Xclk;
    end
    total += 2;
    if (t2 < 0 || t2 - t1 != 4) begin
      bad++;
      $display("FAIL div_period: got %0d clk, required 4", t2 < 0 ? -1 : t2 - t1);
    end
    if (Pclk !== Xclk) begin bad++; $display("FAIL pclk: got %b required %b", Pclk, Xclk); end
  endtask

  task automatic test_frame();
    int f0 = fd_cnt;
    capture = 1'b1;
    slot(1'b0, 1'b0, 8'h00);
    slot(1'b0, 1'b0, 8'h00);
    vpulse();
    line(4, 8'h12, 8'h22, 0);
    line(2, 8'h12, 8'h22, 1);
    slot(1'b1, 1'b0, 8'h00);
    slot(1'b1, 1'b0, 8'h00);
    chk_done("frame", f0, 1);
  endtask

  task automatic test_long_line();
    int f0 = fd_cnt;
    slot(1'b0, 1'b0, 8'h00);
    slot(1'b0, 1'b0, 8'h00);
    line(2 * H + 4, 8'hA0, 8'h01, 0);
    line(3, 8'h11, 8'h11, 1);
    line(2, 8'h44, 8'h11, 2);
    line(2, 8'h66, 8'h01, 3);
    slot(1'b1, 1'b0, 8'h00);
    slot(1'b1, 1'b0, 8'h00);
    chk_done("long_line", f0, 1);
    total++;
    if (pix_addr !== AW'(2 * H)) begin
      bad++;
      $display("FAIL addr_hold: got %0d required %0d", pix_addr, 2 * H);
    end
  endtask

  task automatic test_abort();
    int f0 = fd_cnt;
    slot(1'b0, 1'b0, 8'h00);
    slot(1'b0, 1'b0, 8'h00);
    sb.push_back({AW'(0), 16'hDEAD});
    slot(1'b0, 1'b1, 8'hDE);
    slot(1'b0, 1'b1, 8'hAD);
    repeat (2) @(negedge clk);
    capture = 1'b0;
    slot(1'b0, 1'b1, 8'hBE);
    slot(1'b0, 1'b1, 8'hEF);
    slot(1'b0, 1'b0, 8'h00);
    slot(1'b1, 1'b0, 8'h00);
    slot(1'b1, 1'b0, 8'h00);
    slot(1'b0, 1'b0, 8'h00);
    capture = 1'b1;
    slot(1'b0, 1'b1, 8'h01);
    slot(1'b0, 1'b1, 8'h02);
    slot(1'b0, 1'b0, 8'h00);
    chk_done("abort", f0, 0);
  endtask

  task automatic test_reset_mid();
    int f0;
    vpulse();
    sb.push_back({AW'(0), 16'h0102});
    slot(1'b0, 1'b1, 8'h01);
    slot(1'b0, 1'b1, 8'h02);
    slot(1'b0, 1'b1, 8'h03);
    rst = 1'b0;
    #1;
    total += 6;
    if (Xclk !== 1'b0) begin bad++; $display("FAIL mid_rst_xclk: got %b required 0", Xclk); end
    if (reset !== 1'b0) begin bad++; $display("FAIL mid_rst_reset: got %b required 0", reset); end
    if (PWDN !== 1'b1) begin bad++; $display("FAIL mid_rst_pwdn: got %b required 1", PWDN); end
    if (pix_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we: got %b required 0", pix_we); end
    if (pix_addr !== '0) begin bad++; $display("FAIL mid_rst_addr: got %0d required 0", pix_addr); end
    if (pix_data !== 16'h0) begin bad++; $display("FAIL mid_rst_data: got %h required 0000", pix_data); end
    repeat (3) @(negedge clk);
    Href = 1'b0;
    data = 8'h00;
    rst  = 1'b1;
    @(negedge clk);
    f0 = fd_cnt;
    slot(1'b0, 1'b1, 8'h05);
    slot(1'b0, 1'b1, 8'h06);
    slot(1'b0, 1'b0, 8'h00);
    slot(1'b0, 1'b0, 8'h00);
    vpulse();
    line(2, 8'h07, 8'h01, 0);
    slot(1'b1, 1'b0, 8'h00);
    slot(1'b1, 1'b0, 8'h00);
    chk_done("reset_mid", f0, 1);
  endtask

  initial begin
    test_reset();
    test_divider();
    test_frame();
    test_long_line();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
